dac_sample_feeder: RTL

//  Upstream stage of the AD5061 DAC serializer. Buffers 16-bit samples written by the

---
 rtl/dac_sample_feeder_if.sv | 35 +++
 rtl/dac_sample_feeder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_feeder_if
// Description : Host/serializer-facing bundle of the DAC sample feeder.
//               master modport = host and waveform logic (pushes samples,
//               controls pacing); slave modport = the feeder itself.
// Signals     : wr_en/wr_data (sample push), full/level (FIFO status),
//               enable (pacing run), latch/value (to DAC serializer),
//               underrun/underrun_clr (sticky empty-period flag).
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_sample_feeder_if #(
    parameter int FIFO_AW = 4
);
    logic              wr_en;
    logic [15:0]       wr_data;
    logic              full;
    logic [FIFO_AW:0]  level;
    logic              enable;
    logic              latch;
    logic [15:0]       value;
    logic              underrun;
    logic              underrun_clr;

    modport master (
        output wr_en, wr_data, enable, underrun_clr,
        input  full, level, latch, value, underrun
    );

    modport slave (
        input  wr_en, wr_data, enable, underrun_clr,
        output full, level, latch, value, underrun
    );
endinterface
`default_nettype wire

// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_feeder
// Description : Buffers 16-bit DAC samples in a first-word-fall-through FIFO
//               and releases one per RATE_DIV clock cycles as a single-cycle
//               latch pulse with a stable value for the AD5061 serializer.
//               A sample period that ends with the FIFO empty sets a sticky
//               underrun flag.
// Ports       : clk, reset (sync, active-high)
//               bus (dac_sample_feeder_if.slave):
//                 wr_en, wr_data  -> sample push (dropped while full)
//                 full, level     <- FIFO status
//                 enable          -> pacing run / hold
//                 latch, value    <- serializer strobe and sample
//                 underrun        <- sticky empty-period flag
//                 underrun_clr    -> clears underrun (set wins)
// Options     : DAC_FEEDER_REPEAT_EN - on an empty period, pulse latch with
//               the previous value so the DAC frame cadence is preserved.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_feeder #(
    parameter int          FIFO_AW   = 4,
    parameter int          RATE_DIV  = 100,
    parameter logic [15:0] RST_VALUE = 16'h0000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dac_sample_feeder_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FIFO_AW:0]  wr_cnt_q, wr_cnt_d;
    logic [FIFO_AW:0]  rd_cnt_q, rd_cnt_d;
    logic [15:0]       value_q, value_d;
    logic              latch_q, latch_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       mem_q [DEPTH];

    logic              tick;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [FIFO_AW:0]  level;

    always_comb begin
        // Counts are one bit wider than the pointers, so the difference is
        // the true occupancy 0..DEPTH even after the pointers wrap.
        level = wr_cnt_q - rd_cnt_q;
        empty = (level == '0);
        full  = level[FIFO_AW];

        tick  = bus.enable && (cnt_q == '0);
        if (!bus.enable) begin
            cnt_d = RELOAD;
        end else if (tick) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        // Acceptance looks only at this cycle's full, so a write arriving in
        // the same cycle as a pop from a full FIFO is still dropped.
        push = bus.wr_en && !full;
        // An empty FIFO is judged before this cycle's write lands.
        pop  = tick && !empty;

        wr_cnt_d = wr_cnt_q + (FIFO_AW + 1)'(push);
        rd_cnt_d = rd_cnt_q + (FIFO_AW + 1)'(pop);

        value_d = pop ? mem_q[rd_cnt_q[FIFO_AW-1:0]] : value_q;
`ifdef DAC_FEEDER_REPEAT_EN
        latch_d = tick;
`else
        latch_d = pop;
`endif

        underrun_d = underrun_q;
        if (bus.underrun_clr) begin
            underrun_d = 1'b0;
        end
        if (tick && empty) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= RELOAD;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            value_q    <= RST_VALUE;
            latch_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            value_q    <= value_d;
            latch_q    <= latch_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_cnt_q[FIFO_AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full     = full;
    assign bus.level    = level;
    assign bus.latch    = latch_q;
    assign bus.value    = value_q;
    assign bus.underrun = underrun_q;

endmodule
`default_nettype wire
